// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-serial instruction loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int         BYTES_PER_WORD    = 7;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/loader_checksum.sv
// Purpose: 8-bit XOR accumulator over accepted frame bytes, with synchronous clear.
// Latency: sum reflects a byte on the cycle after it is enabled.
// Backpressure: none; the caller gates en with its own handshake.
module loader_checksum (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sum <= 8'd0;
        end else if (en) begin
            sum <= sum ^ data;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Purpose: framed byte stream -> 49-bit instruction words into imem; holds CPU until a clean load.
// Latency: imem_we one cycle after the 7th byte of a word; status one cycle after the frame ends.
// Backpressure: in_ready drops for exactly the write cycle of each word. Trailing checksum under LOADER_CHECKSUM_EN.
module prog_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 6,
    parameter int         WORD_W    = 49,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int               CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;
    localparam logic [7:0]       MAX_CNT   = 8'(1 << ADDR_W);
    localparam int               SHIFT_W   = 8 * (BYTES_PER_WORD - 1);
    localparam logic [2:0]       LAST_BYTE = 3'(BYTES_PER_WORD - 1);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHECK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t             state, state_nxt;
    logic [SHIFT_W-1:0] shift_q;
    logic [2:0]         byte_idx;
    logic [CNT_W-1:0]   words_left;
    logic               accept;
    logic               idle_like;
    logic               sync_hit;

    assign accept    = in_valid && in_ready;
    assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);
    assign sync_hit  = accept && idle_like && (in_data == SYNC_BYTE);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    loader_checksum u_checksum (
        .clk   (clk),
        .reset (reset),
        .clr   (sync_hit),
        .en    (accept && (state == COUNT || state == DATA)),
        .data  (in_data),
        .sum   (csum)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERROR: if (sync_hit) state_nxt = COUNT;
            COUNT: if (accept) state_nxt = (in_data > MAX_CNT) ? ERROR : DATA;
            // Upper seven bits of the last byte are reserved; a dirty word is dropped.
            DATA: if (accept && byte_idx == LAST_BYTE)
                      state_nxt = (in_data[7:1] == 7'd0) ? WRITE : ERROR;
            WRITE: state_nxt = (words_left == CNT_W'(1)) ? END_STATE : DATA;
`ifdef LOADER_CHECKSUM_EN
            CHECK: if (accept) state_nxt = (in_data == csum) ? DONE : ERROR;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imem_addr  <= '0;
            imem_wdata <= '0;
            shift_q    <= '0;
            byte_idx   <= 3'd0;
            words_left <= '0;
        end else begin
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (sync_hit) begin
                        imem_addr <= '0;
                        byte_idx  <= 3'd0;
                    end
                end
                COUNT: begin
                    if (accept) words_left <= (in_data == 8'd0) ? MAX_WORDS : CNT_W'(in_data);
                end
                DATA: begin
                    if (accept) begin
                        if (byte_idx == LAST_BYTE) begin
                            imem_wdata <= {in_data[0], shift_q};
                            byte_idx   <= 3'd0;
                        end else begin
                            shift_q  <= {in_data, shift_q[SHIFT_W-1:8]};
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    imem_addr  <= imem_addr + ADDR_W'(1);
                    words_left <= words_left - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered off the next state so they never glitch or follow in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready <= 1'b1;
            imem_we  <= 1'b0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            in_ready <= (state_nxt != WRITE);
            imem_we  <= (state_nxt == WRITE);
            cpu_hold <= (state_nxt != DONE);
            done     <= (state_nxt == DONE);
            error    <= (state_nxt == ERROR);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized frames driven into prog_loader; expected writes are queued by the frame model and popped by a monitor.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [48:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0]  addr;
        logic [48:0] data;
        int          cyc;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [48:0] words[64];
    int          last_cyc;
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write must match the next queued expectation, including its cycle.
    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready_low_only_on_write", {63'd0, in_ready}, {63'd0, !imem_we});
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", imem_addr, imem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write_addr", {58'd0, imem_addr}, {58'd0, mon_e.addr});
                    chk("write_data", {15'd0, imem_wdata}, {15'd0, mon_e.data});
                    chk("write_cycle", 64'(cyc), 64'(mon_e.cyc));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte has transferred.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        last_cyc = cyc;
        if (!ok) begin
            checks++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 8 cycles, expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready",   {63'd0, in_ready}, 64'd1);
        chk("rst_imem_we",    {63'd0, imem_we},  64'd0);
        chk("rst_imem_addr",  {58'd0, imem_addr}, 64'd0);
        chk("rst_imem_wdata", {15'd0, imem_wdata}, 64'd0);
        chk("rst_cpu_hold",   {63'd0, cpu_hold}, 64'd1);
        chk("rst_done",       {63'd0, done},     64'd0);
        chk("rst_error",      {63'd0, error},    64'd0);
    endtask

    task automatic fill_random_words();
        logic [63:0] r;
        for (int i = 0; i < 64; i++) begin
            r = {$urandom(), $urandom()};
            words[i] = r[48:0];
        end
    endtask

    // Frame model: words before the first dirty word are written at addr 0..; the frame
    // succeeds only if count <= 64, no word is dirty and (when enabled) the checksum matches.
    task automatic run_frame(input logic [7:0] cnt, input int bad_word, input bit bad_csum);
        logic [7:0]  csum;
        logic [7:0]  b;
        logic [48:0] w;
        int          n;
        int          k = 1;
        bit          failed = 0;
        send_byte(8'hA5);
        send_byte(cnt);
        csum = cnt;
        n = (cnt == 8'd0) ? 64 : int'(cnt);
        if (cnt > 8'd64) failed = 1;
        for (int i = 0; i < n && !failed; i++) begin
            w = words[i];
            for (int j = 0; j < 6; j++) begin
                b = w[8*j +: 8];
                send_byte(b);
                csum ^= b;
            end
            b = {7'd0, w[48]};
            if (i == bad_word) b = b | {7'($urandom_range(1, 127)), 1'b0};
            send_byte(b);
            csum ^= b;
            if (i == bad_word) failed = 1;
            else exp_q.push_back('{6'(i), w, last_cyc + 1});
        end
`ifdef LOADER_CHECKSUM_EN
        if (!failed) begin
            send_byte(bad_csum ? ~csum : csum);
            failed = bad_csum;
        end
`else
        if (!failed) k = 2;
`endif
        repeat (k) @(negedge clk);
        chk("status_done",     {63'd0, done},     {63'd0, !failed});
        chk("status_error",    {63'd0, error},    {63'd0, failed});
        chk("status_cpu_hold", {63'd0, cpu_hold}, {63'd0, failed});
        chk("pending_writes",  64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed single word 11 22 33 44 55 66 01.
        words[0] = 49'h1_6655_4433_2211;
        run_frame(8'h01, -1, 0);

        // Full 64-word frame.
        fill_random_words();
        run_frame(8'h00, -1, 0);

        // Second word dirty, then a clean frame clears the error.
        fill_random_words();
        run_frame(8'h02, 1, 0);
        fill_random_words();
        run_frame(8'h03, -1, 0);

        // Wrong checksum (only an error when the checksum is enabled).
        fill_random_words();
        run_frame(8'h01, -1, 1);

        // Garbage before sync, then an oversized count.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        run_frame(8'h41, -1, 0);

        // Reset three bytes into a word, then a clean reload from address 0.
        send_byte(8'hA5);
        send_byte(8'h01);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        reset = 1'b0;
        fill_random_words();
        run_frame(8'h02, -1, 0);

        // Randomized frames.
        for (int t = 0; t < 8; t++) begin
            logic [7:0] c;
            int         bw;
            c  = 8'($urandom_range(1, 6));
            bw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(c) - 1)) : -1;
            fill_random_words();
            run_frame(c, bw, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
